tagctrl_mem_arbiter: RTL and testbench
======================================

TAGCTRL_MEM_ARBITER -- requirements
Module: tagctrl_mem_arbiter

Interface
REQ-001 Parameters (name, default, meaning):
- AddrWidth, 64, address width of requester and memory ports.
- DataWidth, 64, data width; byte-enable width is DataWidth/8.
- MaxLockBeats, 16, maximum consecutive grants one locked requester may hold while the other requester waits (range 1..255).
REQ-002 Clocking: one clock; reset is asynchronous and active-high.
REQ-003 Ports (name, direction, width, meaning):
- clk_i, in, 1, clock, rising edge.
- rst_i, in, 1, asynchronous active-high reset.
- req_i, in, 2, per-requester access request; index 0 = data path, 1 = tag path.
- lock_i, in, 2, per-requester request to keep ownership across consecutive beats.
- we_i, in, 2, per-requester write enable.
- addr_i, in, 2 x AddrWidth, per-requester word address.
- be_i, in, 2 x DataWidth/8, per-requester byte enables.
- wdata_i, in, 2 x DataWidth, per-requester write data.
- gnt_o, out, 2, per-requester grant, same cycle as the request.
- rvalid_o, out, 2, per-requester read data valid.
- rdata_o, out, DataWidth, read data, shared by both requesters.
- mem_req_o, out, 1, SRAM request.
- mem_we_o, out, 1, SRAM write enable.
- mem_addr_o, out, AddrWidth, SRAM address.
- mem_be_o, out, DataWidth/8, SRAM byte enables.
- mem_wdata_o, out, DataWidth, SRAM write data.
- mem_rdata_i, in, DataWidth, SRAM read data, valid exactly 1 cycle after an accepted read.

Function
REQ-004 The SRAM accepts one access every cycle; there is no back-pressure from the memory.
REQ-005 The arbiter is combinational from req_i to the grant: mem_req_o = req_i[0] | req_i[1], and at most one gnt_o bit is high in any cycle.
REQ-006 gnt_o[i] is high only when req_i[i] is high and requester i wins arbitration.
REQ-007 mem_we_o, mem_addr_o, mem_be_o and mem_wdata_o carry the winner's fields; they are all zero when no requester wins.
REQ-008 Winner selection, in priority order:
- a) The lock owner, if the lock is active and the owner has req_i high.
- b) Otherwise, the single requesting port.
- c) Otherwise, when both request, the port named by the round-robin pointer rr_q.
REQ-009 After any grant to port i, rr_q updates to 1-i on the next edge; rr_q is unchanged in cycles with no grant.
REQ-010 Lock acquisition: a grant to port i with lock_i[i]=1 while no lock is active sets owner_q=i and lock_active_q=1, and sets lock_cnt_q=1.
REQ-011 Lock counting:
- Each further grant to the owner with lock_i high increments lock_cnt_q, saturating at MaxLockBeats.
- lock_cnt_q counts only while the other port has req_i high; it holds its value otherwise.
REQ-012 Lock release on the next edge when any of these holds:
- the owner is granted with lock_i[owner]=0;
- req_i[owner]=0;
- lock_cnt_q = MaxLockBeats and req_i[1-owner]=1.
On release, lock_active_q=0 and lock_cnt_q=0.
REQ-013 Forced release: in the cycle where lock_cnt_q = MaxLockBeats and the other port requests, the other port wins regardless of the lock, and rr_q then points back to the former owner.
REQ-014 Read return:
- A granted access with we=0 registers rd_pend_q=1 and rd_idx_q=i.
- The next cycle, rvalid_o[rd_idx_q]=1 and rdata_o=mem_rdata_i.
- Read latency is exactly 1 cycle.
- Back-to-back reads from alternating ports return in grant order, one per cycle.
REQ-015 Granted writes never produce rvalid_o.
REQ-016 rdata_o is driven as mem_rdata_i when no rvalid_o bit is high; consumers qualify it with rvalid_o.
REQ-017 Simultaneous events: a lock request and a forced release in the same cycle resolve as release-first; the newly granted port may then acquire the lock in that same grant.

Reset
REQ-018 While rst_i is high, asynchronously and independent of the clock: rr_q=0, lock_active_q=0, owner_q=0, lock_cnt_q=0, rd_pend_q=0, rd_idx_q=0, and rvalid_o=0.
REQ-019 A read granted in the cycle that rst_i asserts returns no rvalid_o.
REQ-020 Combinational outputs (gnt_o, mem_*) follow REQ-005 to REQ-008 with reset register values while reset is asserted.

Verification
REQ-021 Both ports read every cycle, lock_i=0, from reset -> grants alternate 0,1,0,1; rvalid_o alternates 0,1,0,1 one cycle later, with rdata_o matching the SRAM word at each address.
REQ-022 Port 0 writes 0xDEADBEEF_CAFEF00D with be=0xFF at addr 0x10, then port 1 reads addr 0x10 -> rvalid_o[1]=1 one cycle after its grant, with rdata_o=0xDEADBEEF_CAFEF00D.
REQ-023 MaxLockBeats=4; port 0 holds req and lock high continuously while port 1 requests from cycle 0 -> port 0 is granted 4 consecutive beats, then port 1 for 1 beat, then port 0 regains the lock.
REQ-024 Port 1 locked; lock_i[1] drops after 2 beats while port 0 waits -> the next cycle grants port 0; lock_cnt_q=0.
REQ-025 rst_i pulses in the same cycle as a granted read -> no rvalid_o, and first grant after reset with both requesting goes to port 0.
REQ-026 Random req/lock/we stimulus for 10k cycles -> never two grants per cycle; no port waits more than MaxLockBeats+1 cycles while requesting.

Source files
------------

// File: rtl/tagctrl_mem_arbiter.sv
// tagctrl_mem_arbiter: two-port (data/tag) arbiter in front of a single-cycle SRAM.
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   req_i/lock_i/we_i            per-requester request, lock, write enable (0 = data, 1 = tag)
//   addr_i/be_i/wdata_i          per-requester access fields
//   gnt_o                        per-requester same-cycle grant (one-hot or zero)
//   rvalid_o, rdata_o            per-requester read-valid, shared read data
//   mem_*_o, mem_rdata_i         SRAM port; read data arrives one cycle after the read
module tagctrl_mem_arbiter #(
    parameter int unsigned AddrWidth    = 64,
    parameter int unsigned DataWidth    = 64,
    parameter int unsigned MaxLockBeats = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [1:0]                    req_i,
    input  logic [1:0]                    lock_i,
    input  logic [1:0]                    we_i,
    input  logic [1:0][AddrWidth-1:0]     addr_i,
    input  logic [1:0][DataWidth/8-1:0]   be_i,
    input  logic [1:0][DataWidth-1:0]     wdata_i,
    output logic [1:0]                    gnt_o,
    output logic [1:0]                    rvalid_o,
    output logic [DataWidth-1:0]          rdata_o,
    output logic                          mem_req_o,
    output logic                          mem_we_o,
    output logic [AddrWidth-1:0]          mem_addr_o,
    output logic [DataWidth/8-1:0]        mem_be_o,
    output logic [DataWidth-1:0]          mem_wdata_o,
    input  logic [DataWidth-1:0]          mem_rdata_i
);
    localparam int unsigned CntWidth = $clog2(MaxLockBeats + 1);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxLockBeats);

    logic                rr_q, rr_d;
    logic                lock_active_q, lock_active_d;
    logic                owner_q, owner_d;
    logic [CntWidth-1:0] lock_cnt_q, lock_cnt_d;
    logic                rd_pend_q, rd_pend_d;
    logic                rd_idx_q, rd_idx_d;

    logic other, forced, owner_wins, any_gnt, win, release_lock, acquire;

    always_comb begin
        other        = ~owner_q;
        // The waiting port takes the beat once the owner has used up its budget.
        forced       = lock_active_q && (lock_cnt_q == CntMax) && req_i[other];
        owner_wins   = lock_active_q && req_i[owner_q] && !forced;
        any_gnt      = |req_i;
        // With a single requester, req_i[1] names it; with two, rr_q decides.
        win          = forced ? other : owner_wins ? owner_q : (&req_i) ? rr_q : req_i[1];
        gnt_o        = any_gnt ? (win ? 2'b10 : 2'b01) : 2'b00;
        mem_req_o    = any_gnt;
        mem_we_o     = any_gnt ? we_i[win] : 1'b0;
        mem_addr_o   = any_gnt ? addr_i[win] : '0;
        mem_be_o     = any_gnt ? be_i[win] : '0;
        mem_wdata_o  = any_gnt ? wdata_i[win] : '0;
        rdata_o      = mem_rdata_i;
        rvalid_o     = {rd_pend_q & rd_idx_q, rd_pend_q & ~rd_idx_q};
        // When the owner still requests and is not forced out it is the winner,
        // so a dropped lock_i on the owner releases after this grant.
        release_lock = lock_active_q && (!req_i[owner_q] || forced || !lock_i[owner_q]);
        // Release resolves first, so the new winner may take the lock in the same grant.
        acquire      = (!lock_active_q || release_lock) && any_gnt && lock_i[win];
        rr_d         = any_gnt ? ~win : rr_q;
        lock_active_d = lock_active_q && !release_lock ? 1'b1 : acquire;
        owner_d      = acquire ? win : owner_q;
        lock_cnt_d   = (lock_active_q && !release_lock)
                       ? ((req_i[other] && lock_cnt_q < CntMax) ? lock_cnt_q + CntWidth'(1) : lock_cnt_q)
                       : (acquire ? CntWidth'(1) : '0);
        rd_pend_d    = any_gnt && !we_i[win];
        rd_idx_d     = win;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q          <= 1'b0;
            lock_active_q <= 1'b0;
            owner_q       <= 1'b0;
            lock_cnt_q    <= '0;
            rd_pend_q     <= 1'b0;
            rd_idx_q      <= 1'b0;
        end else begin
            rr_q          <= rr_d;
            lock_active_q <= lock_active_d;
            owner_q       <= owner_d;
            lock_cnt_q    <= lock_cnt_d;
            rd_pend_q     <= rd_pend_d;
            rd_idx_q      <= rd_idx_d;
        end
    end
endmodule

// File: tb/tb_tagctrl_mem_arbiter.sv
// tb_tagctrl_mem_arbiter: vector table, directed corners and random run against a reference model.
module tb_tagctrl_mem_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int BW = 8;
    localparam int ML = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [1:0]           req, lock, we;
    logic [1:0][AW-1:0]   addr;
    logic [1:0][BW-1:0]   be;
    logic [1:0][DW-1:0]   wdata;
    logic [1:0]           gnt, rvalid;
    logic [DW-1:0]        rdata, mem_rdata, mem_wdata;
    logic                 mem_req, mem_we;
    logic [AW-1:0]        mem_addr;
    logic [BW-1:0]        mem_be;

    tagctrl_mem_arbiter #(.AddrWidth(AW), .DataWidth(DW), .MaxLockBeats(ML)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .lock_i(lock), .we_i(we),
        .addr_i(addr), .be_i(be), .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid),
        .rdata_o(rdata), .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    logic [DW-1:0] sram [256];
    logic [DW-1:0] refm [256];

    always @(posedge clk) begin
        if (mem_req && mem_we)
            for (int b = 0; b < BW; b++)
                if (mem_be[b]) sram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        mem_rdata <= sram[mem_addr[7:0]];
    end

    int nvec = 0, nerr = 0;
    int m_rr, m_owner, m_beats, w, pend_port;
    bit pend;
    logic [DW-1:0] pend_data;
    int waitc [2];

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int pick();
        if (m_owner >= 0 && m_beats == ML && req[1-m_owner]) return 1 - m_owner;
        if (m_owner >= 0 && req[m_owner]) return m_owner;
        if (req == 2'b11) return m_rr;
        if (req[0]) return 0;
        if (req[1]) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_rr = 0; m_owner = -1; m_beats = 0; pend = 0; pend_port = 0;
        waitc[0] = 0; waitc[1] = 0;
    endtask

    task automatic check_cycle();
        logic [1:0] eg;
        @(negedge clk);
        w = pick();
        eg = (w < 0) ? 2'b00 : (w == 1 ? 2'b10 : 2'b01);
        cmp("gnt", 64'(gnt), 64'(eg));
        cmp("mem_req", 64'(mem_req), 64'(|req));
        cmp("mem_we", 64'(mem_we), w < 0 ? 64'd0 : 64'(we[w]));
        cmp("mem_addr", mem_addr, w < 0 ? 64'd0 : addr[w]);
        cmp("mem_be", 64'(mem_be), w < 0 ? 64'd0 : 64'(be[w]));
        cmp("mem_wdata", mem_wdata, w < 0 ? 64'd0 : wdata[w]);
        cmp("rvalid", 64'(rvalid), pend ? (pend_port == 1 ? 64'd2 : 64'd1) : 64'd0);
        if (pend) cmp("rdata", rdata, pend_data);
        for (int p = 0; p < 2; p++) begin
            waitc[p] = (req[p] && !eg[p]) ? waitc[p] + 1 : 0;
            cmp("wait_bound", 64'(waitc[p] > ML + 1), 64'd0);
        end
    endtask

    task automatic advance();
        bit rel;
        @(posedge clk);
        if (rst) model_reset();
        else begin
            pend = (w >= 0) && !we[w];
            if (w >= 0) begin
                pend_port = w;
                pend_data = refm[addr[w][7:0]];
                if (we[w])
                    for (int b = 0; b < BW; b++)
                        if (be[w][b]) refm[addr[w][7:0]][8*b +: 8] = wdata[w][8*b +: 8];
            end
            rel = (m_owner >= 0) && (!req[m_owner] || !lock[m_owner] || (m_beats == ML && req[1-m_owner]));
            if (m_owner < 0 || rel) begin
                m_owner = (w >= 0 && lock[w]) ? w : -1;
                m_beats = (m_owner >= 0) ? 1 : 0;
            end else if (req[1-m_owner] && m_beats < ML) m_beats++;
            if (w >= 0) m_rr = 1 - w;
        end
        #1;
    endtask

    typedef struct {
        logic [1:0] req, lock, we, gnt, rv;
    } vec_t;
    vec_t tbl [19];

    initial begin
        for (int i = 0; i < 256; i++) begin
            sram[i] = {32'hA500_0000 | 32'(i), 32'h5A5A_0000 ^ 32'(i * 7)};
            refm[i] = sram[i];
        end
        tbl = '{
            '{2'b11, 2'b00, 2'b00, 2'b01, 2'b00}, '{2'b11, 2'b00, 2'b00, 2'b10, 2'b01},
            '{2'b11, 2'b00, 2'b00, 2'b01, 2'b10}, '{2'b11, 2'b00, 2'b00, 2'b10, 2'b01},
            '{2'b11, 2'b01, 2'b00, 2'b01, 2'b10}, '{2'b11, 2'b01, 2'b00, 2'b01, 2'b01},
            '{2'b11, 2'b01, 2'b00, 2'b01, 2'b01}, '{2'b11, 2'b01, 2'b00, 2'b01, 2'b01},
            '{2'b11, 2'b01, 2'b00, 2'b10, 2'b01}, '{2'b11, 2'b01, 2'b00, 2'b01, 2'b10},
            '{2'b10, 2'b10, 2'b00, 2'b10, 2'b01}, '{2'b11, 2'b10, 2'b00, 2'b10, 2'b10},
            '{2'b11, 2'b00, 2'b00, 2'b10, 2'b10}, '{2'b11, 2'b00, 2'b00, 2'b01, 2'b10},
            '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01}, '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00},
            '{2'b01, 2'b00, 2'b01, 2'b01, 2'b00}, '{2'b10, 2'b00, 2'b10, 2'b10, 2'b00},
            '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00}
        };
        rst = 1'b1; req = '0; lock = '0; we = '0; addr = '0; be = '0; wdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        cmp("reset_rvalid", 64'(rvalid), 64'd0);
        cmp("reset_gnt", 64'(gnt), 64'd0);
        cmp("reset_mem_req", 64'(mem_req), 64'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 19; i++) begin
            req = tbl[i].req; lock = tbl[i].lock; we = tbl[i].we;
            addr[0] = 64'(2 * i); addr[1] = 64'(2 * i + 1);
            be = {8'hF0, 8'h0F}; wdata = {{$urandom, $urandom}, {$urandom, $urandom}};
            check_cycle();
            cmp($sformatf("tbl%0d_gnt", i), 64'(gnt), 64'(tbl[i].gnt));
            cmp($sformatf("tbl%0d_rvalid", i), 64'(rvalid), 64'(tbl[i].rv));
            advance();
        end

        req = 2'b01; lock = '0; we = 2'b01; addr[0] = 64'h10; be[0] = 8'hFF;
        wdata[0] = 64'hDEADBEEF_CAFEF00D;
        check_cycle(); advance();
        req = 2'b10; we = 2'b00; addr[1] = 64'h10;
        check_cycle();
        cmp("wr_rd_gnt", 64'(gnt), 64'd2);
        advance();
        req = 2'b00;
        check_cycle();
        cmp("wr_rd_rvalid", 64'(rvalid), 64'd2);
        cmp("wr_rd_rdata", rdata, 64'hDEADBEEF_CAFEF00D);
        advance();

        req = 2'b01; we = 2'b00; addr = {64'h21, 64'h20};
        check_cycle(); advance();
        req = 2'b11;
        check_cycle();
        cmp("pre_rst_gnt", 64'(gnt), 64'd2);
        #1 rst = 1'b1;
        #1;
        cmp("async_rst_rvalid", 64'(rvalid), 64'd0);
        cmp("async_rst_gnt", 64'(gnt), 64'd1);
        advance();
        rst = 1'b0;
        check_cycle();
        cmp("post_rst_gnt", 64'(gnt), 64'd1);
        cmp("post_rst_rvalid", 64'(rvalid), 64'd0);
        advance();

        for (int c = 0; c < 10000; c++) begin
            req = 2'($urandom);
            lock = {$urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7};
            we = {$urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3};
            addr[0] = 64'($urandom_range(0, 31)); addr[1] = 64'($urandom_range(0, 31));
            be = 16'($urandom);
            wdata = {{$urandom, $urandom}, {$urandom, $urandom}};
            check_cycle();
            advance();
        end
        req = '0;
        check_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
